mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Inverse of the main controller's op/func decode: turns symbolic instruction requests (kind + register fields + immediate/target) into 32-bit MIPS machine words for the supported subset (addu, subu, jr, lw, sw, lui, ori, beq, jal, nop).
- Tags each word with its PC and buffers it in a small FIFO.
- Used by the test/boot path to stream programs into instruction memory at BASE_ADDR without a hand-assembled hex file.

Parameters:
- BASE_ADDR, 32'h0000_3000, address of the first emitted word; restored on reset.
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request this cycle
- req_kind  in  4  instruction kind (package constants)
- req_rs  in  5  rs field / base register
- req_rt  in  5  rt field
- req_rd  in  5  rd field
- req_imm  in  16  immediate / branch offset, emitted verbatim
- req_target  in  26  jal instr_index
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head this cycle
- out_instr  out  32  encoded word at FIFO head
- out_addr  out  32  PC of out_instr
- err_illegal  out  1  one-cycle pulse: illegal kind consumed

Behaviour:
- Reset values: FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, PC counter=BASE_ADDR, state=EMIT.
- Reset mid-stream flushes all buffered words with no drain.
- Accept: a request is accepted when req_valid && req_ready.
- req_ready = (state==EMIT) && (count < FIFO_DEPTH). It is registered-state only, with no combinational path from out_ready, so a full FIFO is not ready even if a pop happens in the same cycle.
- Encoding, with fields {op[31:26], rs[25:21], rt[20:16], rd[15:11], sh[10:6], fn[5:0]}:
  - ADDU: {000000, rs, rt, rd, 00000, 100001}
  - SUBU: {000000, rs, rt, rd, 00000, 100011}
  - JR: {000000, rs, 15'b0, 001000}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - LUI: {001111, 00000, rt, imm}. rs is ignored.
  - ORI: {001101, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - JAL: {000011, req_target}
  - NOP: 32'h0
  - Fields unused by a kind are ignored.
- Push: an accepted legal request pushes {PC, word}, then PC <= PC+4. PC wraps modulo 2^32 without error.
- Latency: the word is visible at out_* the cycle after acceptance when the FIFO was empty.
- Pop: on out_valid && out_ready. Simultaneous push and pop keeps count unchanged and preserves order. Output order is strict acceptance order.
- Illegal kind (10..15): the request is consumed (ready was high), err_illegal=1 next cycle for exactly one cycle, no push, PC unchanged.
- out_instr/out_addr are don't-care while out_valid=0, but hold their last value.
- Empty: out_valid=0. Full: req_ready=0.
- State machine: EMIT, PAD. PAD is only reachable with ENCODER_NOP_PAD_EN.

Optional Feature:
- ENCODER_NOP_PAD_EN defined:
  - Accepting BEQ, JAL or JR moves the state to PAD.
  - In PAD, req_ready=0. When count < FIFO_DEPTH, push {PC, 32'h0}, PC += 4, return to EMIT.
  - If the FIFO is full, stay in PAD until space frees.
  - Reset in PAD returns to EMIT.
- Undefined: no delay-slot padding, the state is constant EMIT, and branches are encoded like any other kind.

Decomposition:
- Shared package mips_isa_pkg holds:
  - Kind constants K_NOP=0, K_ADDU=1, K_SUBU=2, K_JR=3, K_LW=4, K_SW=5, K_LUI=6, K_ORI=7, K_BEQ=8, K_JAL=9.
  - Opcode/funct constants, the same values the controller decodes.
  - BASE_ADDR default.
- One sub-module: encoder_fifo, a synchronous FIFO of {addr, instr} with count, push/pop and full/empty. The encode mux and PC/state logic stay in the top.

Test Plan:
- Reset, then ADDU rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_instr=32'h00221821, out_addr=32'h00003000.
- Then ORI rs=0 rt=8 imm=16'h1234 -> out_instr=32'h34081234 at out_addr=32'h00003004. LUI rt=1 imm=16'hABCD with rs=5 -> 32'h3C01ABCD.
- out_ready=0, push 4 requests:
  - req_ready drops after the 4th and a 5th request is held.
  - Raise out_ready: all 5 words emerge in order with addresses +4 apart.
  - Simultaneous push/pop holds count.
- req_kind=4'hF -> err_illegal high for exactly one cycle, no output word. The next legal word takes the unchanged PC.
- BEQ rs=1 rt=2 imm=16'hFFFF at PC A:
  - With ENCODER_NOP_PAD_EN: words 32'h1022FFFF @A then 32'h00000000 @A+4, and req_ready low for one cycle.
  - Without it: the next request lands at A+4.
- JAL target=26'h0000C00 -> 32'h0C000C00. Assert reset with 3 words buffered -> out_valid=0 next cycle and the next word lands at 32'h00003000.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: request kinds, opcode/funct values and the word encoder.
// Used by mips_instr_encoder (optional delay-slot padding via ENCODER_NOP_PAD_EN) and encoder_fifo.
package mips_isa_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

  localparam logic [3:0] K_NOP  = 4'd0;
  localparam logic [3:0] K_ADDU = 4'd1;
  localparam logic [3:0] K_SUBU = 4'd2;
  localparam logic [3:0] K_JR   = 4'd3;
  localparam logic [3:0] K_LW   = 4'd4;
  localparam logic [3:0] K_SW   = 4'd5;
  localparam logic [3:0] K_LUI  = 4'd6;
  localparam logic [3:0] K_ORI  = 4'd7;
  localparam logic [3:0] K_BEQ  = 4'd8;
  localparam logic [3:0] K_JAL  = 4'd9;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } tagged_word_t;

  function automatic logic [31:0] encode_instr(input logic [3:0]  kind,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [4:0]  rd,
                                               input logic [15:0] imm,
                                               input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    case (kind)
      K_ADDU:  w = {OP_SPECIAL, rs, rt, rd, 5'b00000, FN_ADDU};
      K_SUBU:  w = {OP_SPECIAL, rs, rt, rd, 5'b00000, FN_SUBU};
      K_JR:    w = {OP_SPECIAL, rs, 15'b0, FN_JR};
      K_LW:    w = {OP_LW, rs, rt, imm};
      K_SW:    w = {OP_SW, rs, rt, imm};
      K_LUI:   w = {OP_LUI, 5'b00000, rt, imm};
      K_ORI:   w = {OP_ORI, rs, rt, imm};
      K_BEQ:   w = {OP_BEQ, rs, rt, imm};
      K_JAL:   w = {OP_JAL, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic is_legal_kind(input logic [3:0] kind);
    return kind <= K_JAL;
  endfunction

  // Control transfers that get a NOP delay slot appended when padding is enabled
  function automatic logic needs_delay_slot(input logic [3:0] kind);
    return (kind == K_BEQ) || (kind == K_JAL) || (kind == K_JR);
  endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Synchronous FIFO of {addr, instr} words; the head holds the last popped word while empty.
// Part of mips_instr_encoder (optional feature macro ENCODER_NOP_PAD_EN lives in the top).
module encoder_fifo
  import mips_isa_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  tagged_word_t             push_data,
  input  logic                     pop,
  output tagged_word_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tagged_word_t   mem [DEPTH];
  tagged_word_t   last_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '{addr: RESET_ADDR, instr: 32'h0};
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS requests into PC-tagged machine words streamed through a small FIFO.
// Define ENCODER_NOP_PAD_EN to append a NOP delay slot after BEQ, JAL and JR.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] S_EMIT = 1'b0;
  localparam logic [0:0] S_PAD  = 1'b1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [31:0]   pc_q;
  logic          err_q;
  logic          accept;
  logic          legal;
  logic          pad_push;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  tagged_word_t  fifo_data;
  tagged_word_t  fifo_head;

  // Ready depends only on registered state, never on out_ready
  assign req_ready = (state_q == S_EMIT) && (fifo_count < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign legal     = is_legal_kind(req_kind);
  assign pad_push  = (state_q == S_PAD) && !fifo_full;
  assign fifo_push = pad_push || (accept && legal);

  always_comb begin
    fifo_data.addr  = pc_q;
    fifo_data.instr = pad_push ? 32'h0
                    : encode_instr(req_kind, req_rs, req_rt, req_rd, req_imm, req_target);
  end

  always_comb begin
    state_d = state_q;
`ifdef ENCODER_NOP_PAD_EN
    if (pad_push) begin
      state_d = S_EMIT;
    end else if (accept && legal && needs_delay_slot(req_kind)) begin
      state_d = S_PAD;
    end
`else
    state_d = S_EMIT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMIT;
      pc_q    <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if (fifo_push) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  encoder_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .RESET_ADDR (BASE_ADDR)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_data),
    .pop       (out_valid && out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign out_instr   = fifo_head.instr;
  assign out_addr    = fifo_head.addr;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus a random stream
// compared against a queue-based model of the encoder's observable behaviour.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef ENCODER_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_kind = 4'd0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of {addr, instr}, PC, last shown head, pad pending, error pulse
  logic [63:0] m_q[$];
  logic [31:0] m_pc   = BASE;
  logic [63:0] m_last = {BASE, 32'h0};
  bit          m_pad  = 1'b0;
  bit          m_err  = 1'b0;

  mips_instr_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_word(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
    case (k)
      4'd1:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd2:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd3:    return {6'b000000, rs, 15'b0, 6'b001000};
      4'd4:    return {6'b100011, rs, rt, imm};
      4'd5:    return {6'b101011, rs, rt, imm};
      4'd6:    return {6'b001111, 5'b00000, rt, imm};
      4'd7:    return {6'b001101, rs, rt, imm};
      4'd8:    return {6'b000100, rs, rt, imm};
      4'd9:    return {6'b000011, tg};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : m_last;
  endfunction

  function automatic bit exp_ready();
    return !m_pad && (m_q.size() < DEPTH);
  endfunction

  task automatic set_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
    req_valid = 1'b1; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tg;
  endtask

  // Advance one clock; the model follows what should happen at that edge
  task automatic tick();
    int pre;
    bit acc, pop, padc;
    pre  = m_q.size();
    acc  = req_valid && !m_pad && (pre < DEPTH);
    pop  = (pre > 0) && out_ready;
    padc = m_pad && (pre < DEPTH);
    @(posedge clk); #1;
    if (reset) begin
      m_q.delete(); m_pc = BASE; m_last = {BASE, 32'h0}; m_pad = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (pop) m_last = m_q.pop_front();
      if (padc) begin
        m_q.push_back({m_pc, 32'h0}); m_pc += 32'd4; m_pad = 0;
      end else if (acc) begin
        if (req_kind <= 4'd9) begin
          m_q.push_back({m_pc, ref_word(req_kind, req_rs, req_rt, req_rd, req_imm, req_target)});
          m_pc += 32'd4;
          if (PAD_EN && (req_kind == 4'd3 || req_kind == 4'd8 || req_kind == 4'd9)) m_pad = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic drain();
    int budget = 30;
    req_valid = 1'b0; out_ready = 1'b1;
    while ((m_q.size() > 0 || m_pad) && budget > 0) begin tick(); budget--; end
    tick();
    n_checks++;
    if (budget == 0 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL drain: out_valid=%b budget=%0d, required empty", out_valid, budget);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_checks++;
    if ({out_valid, err_illegal, req_ready} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL reset_flags: valid/err/ready=%b%b%b required 001", out_valid, err_illegal, req_ready);
    end
    n_checks++;
    if ({out_addr, out_instr} !== {BASE, 32'h0}) begin
      n_fail++; $display("[TB] FAIL reset_head: got %h/%h required %h/00000000", out_addr, out_instr, BASE);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    set_req(K_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick();
    n_checks++;
    if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h00221821, 32'h00003000}) begin
      n_fail++; $display("[TB] FAIL addu: got v=%b %h@%h required 1 00221821@00003000", out_valid, out_instr, out_addr);
    end
    out_ready = 1'b1;
    set_req(K_ORI, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0); tick();
    n_checks++;
    if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h34081234, 32'h00003004}) begin
      n_fail++; $display("[TB] FAIL ori: got v=%b %h@%h required 1 34081234@00003004", out_valid, out_instr, out_addr);
    end
    set_req(K_LUI, 5'd5, 5'd1, 5'd0, 16'hABCD, 26'h0); tick();
    n_checks++;
    if ({out_instr, out_addr} !== {32'h3C01ABCD, 32'h00003008}) begin
      n_fail++; $display("[TB] FAIL lui: got %h@%h required 3c01abcd@00003008", out_instr, out_addr);
    end
    req_valid = 1'b0; tick();
    n_checks++;
    if ({out_valid, out_instr} !== {1'b0, 32'h3C01ABCD}) begin
      n_fail++; $display("[TB] FAIL hold_empty: got v=%b %h required 0 3c01abcd", out_valid, out_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] safe [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [31:0] prev;
    int seen = 0;
    int budget = 20;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(safe[$urandom_range(0, 6)], 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      tick();
      n_checks++;
      if (req_ready !== exp_ready()) begin
        n_fail++; $display("[TB] FAIL fill_ready[%0d]: got %b required %b", i, req_ready, exp_ready());
      end
    end
    n_checks++;
    if (req_ready !== 1'b0 || m_q.size() != DEPTH) begin
      n_fail++; $display("[TB] FAIL full_hold: req_ready=%b model_count=%0d required 0/%0d", req_ready, m_q.size(), DEPTH);
    end
    out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (req_ready !== 1'b1 || m_q.size() != DEPTH - 1 || {out_addr, out_instr} !== exp_head()) begin
      n_fail++; $display("[TB] FAIL push_pop: ready=%b head=%h/%h required 1 %h", req_ready, out_addr, out_instr, exp_head());
    end
    req_valid = 1'b0;
    prev = out_addr - 32'd4;
    while (m_q.size() > 0 && budget > 0) begin
      n_checks++;
      if (out_valid !== 1'b1 || {out_addr, out_instr} !== exp_head() || out_addr !== prev + 32'd4) begin
        n_fail++; $display("[TB] FAIL drain_order: got %h/%h required %h", out_addr, out_instr, exp_head());
      end
      prev = out_addr; seen++;
      tick(); budget--;
    end
    n_checks++;
    if (seen != DEPTH - 1 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL drain_count: saw %0d words valid=%b required %0d 0", seen, out_valid, DEPTH - 1);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] pc0;
    drain();
    pc0 = m_pc;
    set_req(4'hF, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1); tick(); req_valid = 1'b0;
    n_checks++;
    if ({err_illegal, out_valid} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL illegal_pulse: err/valid=%b%b required 10", err_illegal, out_valid);
    end
    tick();
    n_checks++;
    if ({err_illegal, out_valid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL illegal_one_cycle: err/valid=%b%b required 00", err_illegal, out_valid);
    end
    set_req(K_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick(); req_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_addr} !== {1'b1, pc0}) begin
      n_fail++; $display("[TB] FAIL illegal_pc: got v=%b @%h required 1 @%h", out_valid, out_addr, pc0);
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    drain();
    a = m_pc;
    set_req(K_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0); tick(); req_valid = 1'b0;
    n_checks++;
    if ({out_instr, out_addr} !== {32'h1022FFFF, a} || req_ready !== !PAD_EN) begin
      n_fail++; $display("[TB] FAIL beq: got %h@%h ready=%b required 1022ffff@%h ready=%b", out_instr, out_addr, req_ready, a, !PAD_EN);
    end
    if (PAD_EN) begin
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL pad_ready: got %b required 1", req_ready);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      n_checks++;
      if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h0, a + 32'd4}) begin
        n_fail++; $display("[TB] FAIL pad_word: got v=%b %h@%h required 1 00000000@%h", out_valid, out_instr, out_addr, a + 32'd4);
      end
    end else begin
      out_ready = 1'b1;
      set_req(K_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick();
      req_valid = 1'b0; out_ready = 1'b0;
      n_checks++;
      if ({out_instr, out_addr} !== {32'h00221821, a + 32'd4}) begin
        n_fail++; $display("[TB] FAIL no_pad_next: got %h@%h required 00221821@%h", out_instr, out_addr, a + 32'd4);
      end
    end
    drain();
    set_req(K_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00); tick(); req_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_instr} !== {1'b1, 32'h0C000C00}) begin
      n_fail++; $display("[TB] FAIL jal: got v=%b %h required 1 0c000c00", out_valid, out_instr);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      req_kind = 4'($urandom_range(0, 15));
      req_rs = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
      req_imm = 16'($urandom); req_target = 26'($urandom);
      tick();
      n_checks++;
      if (out_valid !== (m_q.size() > 0) || req_ready !== exp_ready() || err_illegal !== m_err
          || {out_addr, out_instr} !== exp_head()) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got v=%b r=%b e=%b %h/%h required v=%b r=%b e=%b %h", i, out_valid,
                 req_ready, err_illegal, out_addr, out_instr, m_q.size() > 0, exp_ready(), m_err, exp_head());
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 0; i < 3; i++) begin
      set_req(K_SUBU, 5'(i), 5'd4, 5'd5, 16'h0, 26'h0); tick();
    end
    req_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({out_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL reset_flush: valid/ready=%b%b required 01", out_valid, req_ready);
    end
    set_req(K_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick(); req_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_addr} !== {1'b1, BASE}) begin
      n_fail++; $display("[TB] FAIL reset_pc: got v=%b @%h required 1 @%h", out_valid, out_addr, BASE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_branch();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
